// File: rtl/cell_in_arbiter.sv
// Round-robin arbiter sharing the cell-buffer write port among ingress channels.
// A channel owns the port for a whole packet; backpressure is honoured only at cell boundaries.
module cell_in_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned PORT_NUM   = 4,
  parameter int unsigned DESC_WIDTH = 23,
  parameter int unsigned CELL_WORDS = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [PORT_NUM-1:0]            i_ptr_empty,
  input  logic [PORT_NUM*DESC_WIDTH-1:0] i_ptr_dout,
  output logic [PORT_NUM-1:0]            o_ptr_rd,
  input  logic [PORT_NUM-1:0]            i_data_empty,
  input  logic [PORT_NUM*DATA_WIDTH-1:0] i_data_dout,
  output logic [PORT_NUM-1:0]            o_data_rd,
  input  logic                           i_buf_bp,
  output logic [DATA_WIDTH-1:0]          o_cell_data,
  output logic                           o_cell_wr,
  output logic                           o_cell_sop,
  output logic                           o_cell_eop,
  output logic [DESC_WIDTH-1:0]          o_desc,
  output logic                           o_desc_wr,
  output logic [PORT_NUM-1:0]            o_grant,
  output logic [31:0]                    o_pkt_cnt,
  output logic [15:0]                    o_drop_cnt
);

  localparam int unsigned IdxW       = $clog2(PORT_NUM);
  localparam int unsigned WcW        = $clog2(CELL_WORDS);
  localparam int unsigned CellNumLsb = 3;
  localparam int unsigned CellNumW   = 5;

  localparam logic [PORT_NUM-1:0] OneHot0  = {{(PORT_NUM-1){1'b0}}, 1'b1};
  localparam logic [WcW-1:0]      LastWord = WcW'(CELL_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StCheck, StXfer, StDone} state_e;

  state_e                state_q;
  logic [IdxW-1:0]       rr_ptr_q;
  logic [IdxW-1:0]       gnt_q;
  logic [DESC_WIDTH-1:0] desc_q;
  logic [CellNumW-1:0]   cell_left_q;
  logic [WcW-1:0]        word_cnt_q;

  logic [DESC_WIDTH-1:0] ptr_word  [PORT_NUM];
  logic [DATA_WIDTH-1:0] data_word [PORT_NUM];

  always_comb begin
    for (int n = 0; n < PORT_NUM; n++) begin
      ptr_word[n]  = i_ptr_dout[n*DESC_WIDTH +: DESC_WIDTH];
      data_word[n] = i_data_dout[n*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  logic [PORT_NUM-1:0] req;
  logic [IdxW-1:0]     grant_idx;
  logic                grant_vld;
  logic [IdxW:0]       cand_sum;

  assign req = ~i_ptr_empty;

  // First requester strictly after the last served channel, wrapping.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    cand_sum  = '0;
    for (int i = 1; i <= PORT_NUM; i++) begin
      cand_sum = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
      if (cand_sum >= (IdxW+1)'(PORT_NUM)) begin
        cand_sum = cand_sum - (IdxW+1)'(PORT_NUM);
      end
      if (!grant_vld && req[cand_sum[IdxW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand_sum[IdxW-1:0];
      end
    end
  end

  logic [CellNumW-1:0] head_cells;
  logic [CellNumW-1:0] desc_cells;
  logic                ptr_pop;
  logic                data_pop;
  logic                first_word;
  logic                last_word;
  logic                last_cell;

  assign head_cells = ptr_word[grant_idx][CellNumLsb +: CellNumW];
  assign desc_cells = desc_q[CellNumLsb +: CellNumW];
  assign ptr_pop    = reset && (state_q == StIdle) && grant_vld;
  assign data_pop   = reset && (state_q == StXfer) && !i_data_empty[gnt_q];
  assign first_word = (cell_left_q == desc_cells) && (word_cnt_q == '0);
  assign last_word  = (word_cnt_q == LastWord);
  assign last_cell  = (cell_left_q == CellNumW'(1));

  assign o_ptr_rd  = ptr_pop  ? (OneHot0 << grant_idx) : '0;
  assign o_data_rd = data_pop ? (OneHot0 << gnt_q)     : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rr_ptr_q    <= IdxW'(PORT_NUM - 1);
      gnt_q       <= '0;
      desc_q      <= '0;
      cell_left_q <= '0;
      word_cnt_q  <= '0;
      o_cell_data <= '0;
      o_cell_wr   <= 1'b0;
      o_cell_sop  <= 1'b0;
      o_cell_eop  <= 1'b0;
      o_desc      <= '0;
      o_desc_wr   <= 1'b0;
      o_grant     <= '0;
      o_pkt_cnt   <= '0;
      o_drop_cnt  <= '0;
    end else begin
      o_cell_wr  <= 1'b0;
      o_cell_sop <= 1'b0;
      o_cell_eop <= 1'b0;
      o_desc_wr  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_vld) begin
            desc_q      <= ptr_word[grant_idx];
            cell_left_q <= head_cells;
            gnt_q       <= grant_idx;
            if (head_cells == '0) begin
              // Zero-length descriptor: consume it and move the round-robin point on.
              if (o_drop_cnt != 16'hFFFF) begin
                o_drop_cnt <= o_drop_cnt + 16'd1;
              end
              rr_ptr_q <= grant_idx;
              o_grant  <= '0;
            end else begin
              o_grant <= OneHot0 << grant_idx;
              state_q <= StCheck;
            end
          end
        end
        StCheck: begin
          if (!i_buf_bp) begin
            word_cnt_q <= '0;
            state_q    <= StXfer;
          end
        end
        StXfer: begin
          if (data_pop) begin
            o_cell_data <= data_word[gnt_q];
            o_cell_wr   <= 1'b1;
            o_cell_sop  <= first_word;
            o_cell_eop  <= last_word && last_cell;
            word_cnt_q  <= word_cnt_q + 1'b1;
            if (last_word) begin
              cell_left_q <= cell_left_q - 1'b1;
              state_q     <= last_cell ? StDone : StCheck;
            end
          end
        end
        StDone: begin
          o_desc    <= desc_q;
          o_desc_wr <= 1'b1;
          o_pkt_cnt <= o_pkt_cnt + 32'd1;
          rr_ptr_q  <= gnt_q;
          o_grant   <= '0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
